branch_predict_btb: RTL
=======================

BRANCH_PREDICT_BTB -- requirements
Module: branch_predict_btb

Interface
REQ-001 Parameter BTB_DEPTH, default 64, number of direct-mapped BTB entries; SHALL be a power of two, 4..1024.
REQ-002 Parameter RAS_DEPTH, default 8, number of return-address-stack entries; SHALL be a power of two, 2..32.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pcF  input  32  fetch PC to look up.
REQ-006 pred_takeF  output  1  BTB predicts the branch/jump at pcF taken.
REQ-007 pred_pcF  output  32  predicted next PC.
REQ-008 update_en  input  1  resolved-branch update strobe from EX.
REQ-009 update_pc / update_target  input  32 each  PC and resolved target of the resolved instruction.
REQ-010 update_taken  input  1  resolved direction.
REQ-011 ras_pushD / ras_popD  input  1 each  ID decoded jal/jalr (push) or jr $31 (pop).
REQ-012 pc_plus8D  input  32  return address to push.
REQ-013 ras_topD  output  32  current RAS top.
REQ-014 ras_validD  output  1  RAS non-empty.

Function
REQ-015 Index SHALL be pcF[log2(BTB_DEPTH)+1:2]; tag SHALL be the remaining upper PC bits; pcF[1:0] ignored.
REQ-016 Each entry SHALL hold valid, tag, 32-bit target and a 2-bit saturating counter (00 SN, 01 WN, 10 WT, 11 ST).
REQ-017 Lookup SHALL be combinational, zero-cycle: hit = valid && tag match; pred_takeF = hit && counter[1].
REQ-018 pred_pcF SHALL equal the stored target when pred_takeF=1, else pcF+4 (mod 2^32).
REQ-019 On update_en with hit at update_pc: counter SHALL increment (saturate at 11) if taken, decrement (saturate at 00) if not; target SHALL be overwritten only when taken.
REQ-020 On update_en with miss and taken: entry SHALL be allocated (replacing any occupant), valid=1, counter=10, target=update_target.
REQ-021 On update_en with miss and not taken: no BTB state SHALL change.
REQ-022 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents (no bypass); update visible next cycle.
REQ-023 RAS SHALL be circular with a top pointer and an occupancy count of 0..RAS_DEPTH.
REQ-024 Push only: write pc_plus8D at top+1, advance top, count+1 saturating at RAS_DEPTH; push when full SHALL overwrite the oldest entry.
REQ-025 Pop only: retreat top, count-1; pop when empty SHALL change nothing.
REQ-026 Push and pop together: top entry SHALL be replaced by pc_plus8D, pointer and count unchanged; when empty, SHALL behave as push only.
REQ-027 ras_topD SHALL be the entry at top (combinational); ras_validD = (count != 0).
REQ-028 When count reaches 0 through pops, ras_topD is don't-care and consumers SHALL qualify it with ras_validD.

Reset
REQ-029 rst SHALL clear all BTB valid bits, RAS pointer and count in one cycle; targets, tags and counters need not be reset.
REQ-030 Out of reset: pred_takeF=0, pred_pcF=pcF+4, ras_validD=0.
REQ-031 rst SHALL take priority over a same-cycle update_en, push or pop; the update is discarded.

Structure
REQ-032 Shared package SHALL hold the 2-bit counter encodings (SN/WN/WT/ST), the counter-allocate value (WT) and default BTB_DEPTH/RAS_DEPTH constants.
REQ-033 RAS SHALL be a separate sub-module return_addr_stack, parametrised by RAS_DEPTH; BTB array and counter logic remain in branch_predict_btb.

Verification
REQ-034 Reset, then pcF=0xBFC00000 -> pred_takeF=0, pred_pcF=0xBFC00004, ras_validD=0.
REQ-035 Update pc=0x80000010 taken target 0x80000100; next cycle pcF=0x80000010 -> pred_takeF=1, pred_pcF=0x80000100; two not-taken updates -> pred_takeF=0.
REQ-036 Four taken updates on one PC -> counter 11; one not-taken -> still predicted taken; aliasing PC (same index, other tag) taken update -> original PC misses.
REQ-037 Same-cycle lookup and allocate at pcF=0x80000020 -> pred_takeF=0 that cycle, 1 the next.
REQ-038 RAS_DEPTH=8: push 9 values 0x10..0x90 -> 8 pops return 0x90..0x20, then ras_validD=0; ninth pop leaves state unchanged.
REQ-039 Push+pop same cycle with top 0x40 and value 0x44 -> ras_topD=0x44, count unchanged; rst asserted with update_en -> no entry allocated.

Source files
------------

// File: rtl/branch_predict_btb_pkg.sv
// branch_predict_btb_pkg: shared counter encodings, allocate value and default sizes for the BTB/RAS.
package branch_predict_btb_pkg;
    localparam int BTB_DEPTH_DEF = 64;
    localparam int RAS_DEPTH_DEF = 8;
    typedef enum logic [1:0] {SN = 2'b00, WN = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
    localparam ctr_t CTR_ALLOC = WT;
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        return taken ? (c == ST ? ST : ctr_t'(c + 2'd1)) : (c == SN ? SN : ctr_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/branch_predict_btb_if.sv
// branch_predict_btb_if: predictor bus grouping fetch lookup, EX update and ID return-stack signals.
// master = pipeline side (drives pcF, update_*, ras_*D requests); slave = predictor (drives predictions, RAS top).
interface branch_predict_btb_if;
    logic [31:0] pcF;
    logic        pred_takeF;
    logic [31:0] pred_pcF;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        ras_pushD;
    logic        ras_popD;
    logic [31:0] pc_plus8D;
    logic [31:0] ras_topD;
    logic        ras_validD;
    modport master (
        output pcF, update_en, update_pc, update_target, update_taken, ras_pushD, ras_popD, pc_plus8D,
        input  pred_takeF, pred_pcF, ras_topD, ras_validD
    );
    modport slave (
        input  pcF, update_en, update_pc, update_target, update_taken, ras_pushD, ras_popD, pc_plus8D,
        output pred_takeF, pred_pcF, ras_topD, ras_validD
    );
endinterface

// File: rtl/branch_predict_btb_ras.sv
// return_addr_stack: circular return-address stack that overwrites its oldest entry when full.
// Ports: clk, rst (sync active-high), push/pop/din requests, top (entry at top pointer), valid (non-empty).
module return_addr_stack #(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] top,
    output logic        valid
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

    logic [31:0]   mem_q [RAS_DEPTH];
    logic [PW-1:0] top_q, top_d, wr_ptr;
    logic [PW:0]   cnt_q, cnt_d;
    logic          empty, rep, adv, ret;

    always_comb begin
        empty  = cnt_q == '0;
        // Push+pop on a non-empty stack replaces the top in place; on empty it is a plain push.
        rep    = push && pop && !empty;
        adv    = push && !rep;
        ret    = pop && !push && !empty;
        wr_ptr = rep ? top_q : top_q + 1'b1;
        top_d  = adv ? top_q + 1'b1 : ret ? top_q - 1'b1 : top_q;
        cnt_d  = (adv && cnt_q != FULL) ? cnt_q + 1'b1 : ret ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr] <= din;
    end

    assign top   = mem_q[top_q];
    assign valid = !empty;
endmodule

// File: rtl/branch_predict_btb.sv
// branch_predict_btb: direct-mapped BTB with 2-bit saturating counters plus a return-address stack.
// Ports: clk, rst (sync active-high); bus (slave) carries the zero-cycle fetch lookup pcF -> pred_takeF/pred_pcF,
// the EX resolution update update_*, and the ID return stack ras_pushD/ras_popD/pc_plus8D -> ras_topD/ras_validD.
module branch_predict_btb
    import branch_predict_btb_pkg::*;
#(
    parameter int BTB_DEPTH = BTB_DEPTH_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input logic                 clk,
    input logic                 rst,
    branch_predict_btb_if.slave bus
);
    localparam int IW = $clog2(BTB_DEPTH);
    localparam int TW = 30 - IW;

    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TW-1:0]        tag_q [BTB_DEPTH];
    logic [31:0]          tgt_q [BTB_DEPTH];
    ctr_t                 ctr_q [BTB_DEPTH];

    logic [IW-1:0] fidx, uidx;
    logic [TW-1:0] ftag, utag;
    logic          fhit, uhit, wr_en;
    ctr_t          wr_ctr;
    logic [31:0]   wr_tgt;
    logic          unused_pc_lsb;

    assign fidx          = bus.pcF[IW+1:2];
    assign ftag          = bus.pcF[31:IW+2];
    assign uidx          = bus.update_pc[IW+1:2];
    assign utag          = bus.update_pc[31:IW+2];
    assign unused_pc_lsb = ^bus.update_pc[1:0];

    // Lookup reads the registered array, so a same-cycle update is only seen next cycle.
    assign fhit           = valid_q[fidx] && tag_q[fidx] == ftag;
    assign bus.pred_takeF = fhit && ctr_q[fidx][1];
    assign bus.pred_pcF   = bus.pred_takeF ? tgt_q[fidx] : bus.pcF + 32'd4;

    always_comb begin
        uhit    = valid_q[uidx] && tag_q[uidx] == utag;
        // A not-taken miss leaves the table alone; reset discards any update.
        wr_en   = !rst && bus.update_en && (uhit || bus.update_taken);
        wr_ctr  = uhit ? ctr_next(ctr_q[uidx], bus.update_taken) : CTR_ALLOC;
        wr_tgt  = bus.update_taken ? bus.update_target : tgt_q[uidx];
        valid_d = valid_q;
        valid_d[uidx] = valid_q[uidx] | wr_en;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[uidx] <= utag;
            tgt_q[uidx] <= wr_tgt;
            ctr_q[uidx] <= wr_ctr;
        end
    end

    return_addr_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ras_pushD),
        .pop   (bus.ras_popD),
        .din   (bus.pc_plus8D),
        .top   (bus.ras_topD),
        .valid (bus.ras_validD)
    );
endmodule
